// File: rtl/rs_dec_frame_ctrl.sv
// rtl/rs_dec_frame_ctrl.sv - RS(16,8) decoder front end: ingest, syndrome capture, ping-pong replay
// Define RS_DEC_STATS_EN to add saturating stat_frames/stat_err/stat_len_err outputs.
module rs_dec_frame_ctrl #(
  parameter int N     = 16,
  parameter int K     = 8,
  parameter int SYM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [SYM_W-1:0]     s_data,
  input  logic                 s_last,
  output logic                 syn_din_val,
  output logic                 syn_din_sop,
  output logic                 syn_din_eop,
  output logic [SYM_W-1:0]     syn_din,
  input  logic                 syndrome_val,
  input  logic [8*(N-K)-1:0]   syndrome,
  output logic                 job_valid,
  input  logic                 job_ready,
  output logic [8*(N-K)-1:0]   job_synd,
  output logic                 job_err,
  output logic                 job_len_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [SYM_W-1:0]     m_data,
  output logic                 m_last
`ifdef RS_DEC_STATS_EN
  ,
  output logic [15:0]          stat_frames,
  output logic [15:0]          stat_err,
  output logic [15:0]          stat_len_err
`endif
);

  localparam int CW = $clog2(N);
  localparam int SW = 8 * (N - K);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {S_FREE, S_FILL, S_SYND, S_READY, S_OUT} slot_t;
  typedef enum logic [1:0] {I_IDLE, I_RUN, I_PAD, I_DROP} ing_t;
  typedef enum logic {R_HDR, R_DATA} rep_t;

  slot_t            slot_st [2];
  logic [SW-1:0]    slot_synd [2];
  logic [1:0]       slot_err, slot_len_err;
  logic [SYM_W-1:0] mem [2][N];

  ing_t          ist, ist_nx;
  rep_t          rep_st, rep_nx;
  logic [CW-1:0] cnt, rcnt;
  logic          wr, rd, live;
  logic          feed, frame_len_err, job_hs, m_hs, syn_hit, syn_idx;

  always_comb begin
    ist_nx        = ist;
    s_ready       = 1'b0;
    feed          = 1'b0;
    syn_din_sop   = 1'b0;
    syn_din_eop   = 1'b0;
    syn_din       = '0;
    frame_len_err = 1'b0;
    case (ist)
      I_IDLE: begin
        s_ready = live && (slot_st[wr] == S_FREE);
        if (s_valid && s_ready) begin
          feed        = 1'b1;
          syn_din_sop = 1'b1;
          syn_din     = s_data;
          ist_nx      = s_last ? I_PAD : I_RUN;
        end
      end
      I_RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          feed    = 1'b1;
          syn_din = s_data;
          if (cnt == LAST) begin
            syn_din_eop   = 1'b1;
            frame_len_err = !s_last;
            ist_nx        = s_last ? I_IDLE : I_DROP;
          end else if (s_last) begin
            ist_nx = I_PAD;
          end
        end
      end
      I_PAD: begin
        // short frame: zero-fill the tail so the syndrome unit always sees N symbols
        feed = 1'b1;
        if (cnt == LAST) begin
          syn_din_eop   = 1'b1;
          frame_len_err = 1'b1;
          ist_nx        = I_IDLE;
        end
      end
      default: begin
        s_ready = 1'b1;
        if (s_valid && s_last) ist_nx = I_IDLE;
      end
    endcase
    syn_din_val = feed;
  end

  always_comb begin
    syn_hit = syndrome_val && ((slot_st[0] == S_SYND) || (slot_st[1] == S_SYND));
    syn_idx = (slot_st[0] == S_SYND) ? 1'b0 : 1'b1;
  end

  always_comb begin
    rep_nx      = rep_st;
    job_valid   = 1'b0;
    job_synd    = '0;
    job_err     = 1'b0;
    job_len_err = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    if (rep_st == R_HDR) begin
      if (slot_st[rd] == S_READY) begin
        job_valid   = 1'b1;
        job_synd    = slot_synd[rd];
        job_err     = slot_err[rd];
        job_len_err = slot_len_err[rd];
        if (job_ready) rep_nx = R_DATA;
      end
    end else begin
      m_valid = 1'b1;
      m_data  = mem[rd][rcnt];
      m_last  = (rcnt == LAST);
      if (m_ready && m_last) rep_nx = R_HDR;
    end
  end

  assign job_hs = job_valid && job_ready;
  assign m_hs   = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (feed) mem[wr][cnt] <= syn_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ist    <= I_IDLE;
      rep_st <= R_HDR;
      cnt    <= '0;
      rcnt   <= '0;
      wr     <= 1'b0;
      rd     <= 1'b0;
      live   <= 1'b0;
    end else begin
      live   <= 1'b1;
      ist    <= ist_nx;
      rep_st <= rep_nx;
      if (feed) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (syn_din_eop) wr <= ~wr;
      if (m_hs) rcnt <= m_last ? '0 : rcnt + 1'b1;
      if (m_hs && m_last) rd <= ~rd;
    end
  end

  // Each transition below acts on a slot in a distinct state, so indices never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        slot_st[i]   <= S_FREE;
        slot_synd[i] <= '0;
      end
      slot_err     <= '0;
      slot_len_err <= '0;
    end else begin
      if (syn_din_sop) slot_st[wr] <= S_FILL;
      if (syn_din_eop) begin
        slot_st[wr]      <= S_SYND;
        slot_len_err[wr] <= frame_len_err;
      end
      if (syn_hit) begin
        slot_st[syn_idx]   <= S_READY;
        slot_synd[syn_idx] <= syndrome;
        slot_err[syn_idx]  <= |syndrome;
      end
      if (job_hs) slot_st[rd] <= S_OUT;
      if (m_hs && m_last) slot_st[rd] <= S_FREE;
    end
  end

`ifdef RS_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames  <= '0;
      stat_err     <= '0;
      stat_len_err <= '0;
    end else if (job_hs) begin
      if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      if (job_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      if (job_len_err && stat_len_err != 16'hFFFF) stat_len_err <= stat_len_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_dec_frame_ctrl.sv
// tb/tb_rs_dec_frame_ctrl.sv - directed bench for rs_dec_frame_ctrl
// Syndrome stub: byte (i%8) accumulates sym[i]^i, so frame 0x00..0x0F yields all-zero syndromes.
module tb_rs_dec_frame_ctrl;
  localparam int N = 16, K = 8, SYM_W = 8, LIM = 500;

  logic clk = 1'b0, rst = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0] s_data = '0;
  logic syn_din_val, syn_din_sop, syn_din_eop;
  logic [7:0] syn_din;
  logic syndrome_val = 1'b0;
  logic [63:0] syndrome = '0;
  logic job_valid, job_ready = 1'b0, job_err, job_len_err;
  logic [63:0] job_synd;
  logic m_valid, m_ready = 1'b0, m_last;
  logic [7:0] m_data;
`ifdef RS_DEC_STATS_EN
  logic [15:0] stat_frames, stat_err, stat_len_err;
`endif

  always #5 clk = ~clk;

  rs_dec_frame_ctrl #(.N(N), .K(K), .SYM_W(SYM_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .syn_din_val(syn_din_val), .syn_din_sop(syn_din_sop), .syn_din_eop(syn_din_eop), .syn_din(syn_din),
    .syndrome_val(syndrome_val), .syndrome(syndrome),
    .job_valid(job_valid), .job_ready(job_ready), .job_synd(job_synd), .job_err(job_err),
    .job_len_err(job_len_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef RS_DEC_STATS_EN
    , .stat_frames(stat_frames), .stat_err(stat_err), .stat_len_err(stat_len_err)
`endif
  );

  logic [24:0] out_bits;
  assign out_bits = {s_ready, syn_din_val, syn_din_sop, syn_din_eop, syn_din, job_valid,
                     job_err, job_len_err, m_valid, m_data, m_last};

  int checks = 0, fails = 0;
  int fed_n = 0, eop_at = -1, sop_cnt = 0, idle_bad = 0;
  logic [7:0] fed_sym [16];
  logic [63:0] acc = '0;
  logic [7:0] tx [32];
  logic [7:0] tx3 [32];
  logic [7:0] ex [16];

  always @(posedge clk) begin
    syndrome_val <= 1'b0;
    if (syn_din_val) begin
      if (syn_din_sop) begin
        fed_n = 0;
        acc = '0;
        sop_cnt++;
      end
      fed_sym[fed_n % 16] = syn_din;
      acc = acc ^ (64'(syn_din ^ 8'(fed_n)) << (8 * (fed_n % 8)));
      if (syn_din_eop) begin
        eop_at = fed_n;
        syndrome_val <= 1'b1;
        syndrome <= acc;
      end
      fed_n++;
    end else if (syn_din_sop || syn_din_eop || syn_din != 8'h00) begin
      idle_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0 clean, 1 symbol 3 xor 0x01, 2 symbol 0 xor 0x80; tail 16..31 = 0xA0+i
  task automatic build(input int kind);
    for (int i = 0; i < 32; i++) tx[i] = (i < 16) ? 8'(i) : 8'(8'hA0 + i);
    if (kind == 1) tx[3] = 8'h02;
    if (kind == 2) tx[0] = 8'h80;
    for (int i = 0; i < 16; i++) ex[i] = tx[i];
  endtask

  task automatic send_frame(input logic [7:0] f [32], input int len, input int upto);
    int w;
    for (int i = 0; i < upto; i++) begin
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = (i == len - 1);
      w = 0;
      while (!s_ready && w < LIM) begin
        @(negedge clk);
        w++;
      end
      if (w >= LIM) begin
        chk("send_timeout", 64'(w), 64'(0));
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic recv_job(input string tag, input logic [7:0] e [16], input logic [63:0] esynd,
                          input logic eerr, input logic elen);
    int w, bad, last_bad;
    w = 0;
    bad = 0;
    last_bad = 0;
    job_ready = 1'b1;
    while (!job_valid && w < LIM) begin
      @(negedge clk);
      w++;
    end
    if (w >= LIM) begin
      chk({tag, "_job_timeout"}, 64'(w), 64'(0));
      job_ready = 1'b0;
      return;
    end
    chk({tag, "_synd"}, job_synd, esynd);
    chk({tag, "_err"}, 64'(job_err), 64'(eerr));
    chk({tag, "_len_err"}, 64'(job_len_err), 64'(elen));
    @(negedge clk);
    job_ready = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      w = 0;
      while (!m_valid && w < LIM) begin
        @(negedge clk);
        w++;
      end
      if (m_data !== e[i]) bad++;
      if (m_last !== (i == N - 1)) last_bad++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk({tag, "_data"}, 64'(bad), 64'(0));
    chk({tag, "_mlast"}, 64'(last_bad), 64'(0));
  endtask

  initial begin
    int n, bad, s0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'(out_bits), 64'(0));
    chk("rst_synd", job_synd, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(s_ready), 64'(1));

    // 1: clean frame
    build(0);
    s0 = sop_cnt;
    send_frame(tx, 16, 16);
    chk("t1_eop_at", 64'(eop_at), 64'(15));
    chk("t1_sop_cnt", 64'(sop_cnt - s0), 64'(1));
    bad = 0;
    for (int i = 0; i < 16; i++) if (fed_sym[i] !== ex[i]) bad++;
    chk("t1_fed", 64'(bad), 64'(0));
    recv_job("t1", ex, 64'h0, 1'b0, 1'b0);

    // 2: symbol 3 corrupted
    build(1);
    send_frame(tx, 16, 16);
    recv_job("t2", ex, 64'h0000_0000_0100_0000, 1'b1, 1'b0);

    // 3: short frame, s_last on the 10th symbol
    build(0);
    send_frame(tx, 10, 10);
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ready_low", 64'(n), 64'(6));
    chk("t3_eop_at", 64'(eop_at), 64'(15));
    bad = 0;
    for (int i = 10; i < 16; i++) begin
      if (fed_sym[i] !== 8'h00) bad++;
      ex[i] = 8'h00;
    end
    chk("t3_pads", 64'(bad), 64'(0));
    recv_job("t3", ex, 64'h0F0E_0D0C_0B0A_0000, 1'b1, 1'b1);

    // 4: 20-symbol frame, tail dropped, then a clean frame
    build(0);
    send_frame(tx, 20, 20);
    chk("t4_fed_n", 64'(fed_n), 64'(16));
    chk("t4_eop_at", 64'(eop_at), 64'(15));
    recv_job("t4", ex, 64'h0, 1'b0, 1'b1);
    send_frame(tx, 16, 16);
    recv_job("t4b", ex, 64'h0, 1'b0, 1'b0);

    // 5: backpressure with both slots full, then drain three jobs in order
    build(0);
    send_frame(tx, 16, 16);
    build(1);
    send_frame(tx, 16, 16);
    chk("t5_backpressure", 64'(s_ready), 64'(0));
    repeat (5) @(negedge clk);
    chk("t5_hold", 64'(s_ready), 64'(0));
    chk("t5_hdr_wait", 64'(job_valid), 64'(1));
    build(2);
    tx3 = tx;
    fork
      send_frame(tx3, 16, 16);
    join_none
    build(0);
    recv_job("t5a", ex, 64'h0, 1'b0, 1'b0);
    build(1);
    recv_job("t5b", ex, 64'h0000_0000_0100_0000, 1'b1, 1'b0);
    build(2);
    recv_job("t5c", ex, 64'h0000_0000_0000_0080, 1'b1, 1'b0);
    wait fork;

    // 6: reset mid-frame discards the buffered corrupted frame
    build(1);
    send_frame(tx, 16, 16);
    build(0);
    send_frame(tx, 16, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", 64'(out_bits), 64'(0));
    chk("t6_rst_synd", job_synd, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    send_frame(tx, 16, 16);
    recv_job("t6", ex, 64'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_no_stale_job", 64'(job_valid), 64'(0));
    chk("syn_idle_zero", 64'(idle_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
